// File: rtl/sync_evt_pkg.sv
// Shared constants and types for the synchronized-input event filter.
// Imported by the glitch filter and the event-reporting top.
package sync_evt_pkg;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } evt_edge_e;

    localparam int FILT_LEN_MAX = 255;

endpackage : sync_evt_pkg

// File: rtl/sync_evt_filter_if.sv
// Event handshake bundle: one held event (edge, count) plus sticky overflow.
// The producer owns valid/edge/count/ovf; the consumer owns ready and ovf_clr.
interface sync_evt_filter_if #(
    parameter int CNT_W = 8
);

    logic             evt_valid;
    logic             evt_ready;
    logic             evt_edge;
    logic [CNT_W-1:0] evt_count;
    logic             evt_ovf;
    logic             ovf_clr;

    modport master (
        output evt_valid,
        output evt_edge,
        output evt_count,
        output evt_ovf,
        input  evt_ready,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_edge,
        input  evt_count,
        input  evt_ovf,
        output evt_ready,
        output ovf_clr
    );

endinterface : sync_evt_filter_if

// File: rtl/sync_glitch_filt.sv
// Stable-count glitch filter for an already-synchronized level, with registered
// one-cycle rise/fall pulses coincident with the new filtered level.
module sync_glitch_filt
    import sync_evt_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic clk_rx,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int          CW   = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] cnt;
    logic          dout_q;
    logic          rise_q;
    logic          fall_q;

    // The counter tracks how many consecutive samples have disagreed with dout;
    // the sample that would make it FILT_LEN flips dout instead.
    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dout_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle and are overridden below with
            // non-blocking assignments, so they can never stretch past one cycle.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (din == dout_q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt    <= '0;
                dout_q <= din;
                rise_q <= din;
                fall_q <= ~din;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule : sync_glitch_filt

// File: rtl/sync_evt_filter.sv
// Filters the synchronized level and reports each filtered edge as a held,
// timestamped event on a valid/ready handshake with sticky overflow.
module sync_evt_filter
    import sync_evt_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 8,
    parameter bit RST_VAL  = 1'b0
) (
    input  logic                      clk_rx,
    input  logic                      rst_n,
    input  logic                      din,
    output logic                      dout,
    output logic                      rise_pulse,
    output logic                      fall_pulse,
    sync_evt_filter_if.master         evt
);

    logic             edge_evt;
    logic             accept;
    logic             load;
    logic             drop;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             valid_q;
    evt_edge_e        edge_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    sync_glitch_filt #(
        .FILT_LEN (FILT_LEN),
        .RST_VAL  (RST_VAL)
    ) u_filt (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .din        (din),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Events are captured from the registered pulses, one cycle after dout moves.
    // A full holding register accepts a new edge only if it is being drained now.
    assign edge_evt = rise_pulse | fall_pulse;
    assign accept   = valid_q & evt.evt_ready;
    assign load     = edge_evt & (~valid_q | evt.evt_ready);
    assign drop     = edge_evt & valid_q & ~evt.evt_ready;
    assign cnt_inc  = edge_cnt + 1'b1;

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            valid_q  <= 1'b0;
            edge_q   <= EDGE_FALL;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (edge_evt) begin
                edge_cnt <= cnt_inc;
            end

            if (load) begin
                valid_q <= 1'b1;
                edge_q  <= rise_pulse ? EDGE_RISE : EDGE_FALL;
                count_q <= cnt_inc;
            end else if (accept) begin
                valid_q <= 1'b0;
            end

            // A drop in the same cycle as a clear must leave the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (evt.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_edge  = edge_q;
    assign evt.evt_count = count_q;
    assign evt.evt_ovf   = ovf_q;

endmodule : sync_evt_filter

// File: tb/tb_sync_evt_filter.sv
// Directed bench: default instance (FILT_LEN=4, CNT_W=8) plus a FILT_LEN=1,
// CNT_W=2 instance for pass-through latency and counter wrap.
module tb_sync_evt_filter;

    logic clk_rx;
    logic rst_n;
    logic din_a;
    logic dout_a;
    logic rise_a;
    logic fall_a;
    logic din_b;
    logic dout_b;
    logic rise_b;
    logic fall_b;
    logic seen_a;

    int n_checks;
    int n_pass;

    sync_evt_filter_if #(.CNT_W(8)) evt_a ();
    sync_evt_filter_if #(.CNT_W(2)) evt_b ();

    sync_evt_filter #(
        .FILT_LEN (4),
        .CNT_W    (8),
        .RST_VAL  (1'b0)
    ) dut_a (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .din        (din_a),
        .dout       (dout_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .evt        (evt_a)
    );

    sync_evt_filter #(
        .FILT_LEN (1),
        .CNT_W    (2),
        .RST_VAL  (1'b0)
    ) dut_b (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .din        (din_b),
        .dout       (dout_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .evt        (evt_b)
    );

    initial begin
        clk_rx = 1'b0;
        forever #5 clk_rx = ~clk_rx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, landing on the following falling edge to sample.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_rx);
            @(negedge clk_rx);
            seen_a = seen_a | rise_a | fall_a;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_rx);
        rst_n = 1'b0;
        @(negedge clk_rx);
        rst_n = 1'b1;
    endtask

    logic [1:0] exp_b [5];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        seen_a   = 1'b0;
        rst_n    = 1'b0;
        din_a    = 1'b0;
        din_b    = 1'b0;
        evt_a.evt_ready = 1'b0;
        evt_a.ovf_clr   = 1'b0;
        evt_b.evt_ready = 1'b1;
        evt_b.ovf_clr   = 1'b0;
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) @(negedge clk_rx);
        check("rst_dout", dout_a, 1'b0);
        check("rst_pulses", {rise_a, fall_a}, 2'b00);
        check("rst_valid", evt_a.evt_valid, 1'b0);
        check("rst_edge", evt_a.evt_edge, 1'b0);
        check("rst_count", evt_a.evt_count, 8'd0);
        check("rst_ovf", evt_a.evt_ovf, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // FILT_LEN=1 pass-through and 2-bit count wrap, each event drained at once.
        for (int i = 0; i < 5; i++) begin
            din_b = ~din_b;
            tick(1);
            check("b_dout", dout_b, din_b);
            check("b_pulse", {rise_b, fall_b}, {din_b, ~din_b});
            tick(1);
            check("b_valid", evt_b.evt_valid, 1'b1);
            check("b_edge", evt_b.evt_edge, din_b);
            check("b_count", evt_b.evt_count, exp_b[i]);
            tick(1);
            check("b_drained", evt_b.evt_valid, 1'b0);
        end

        // Pulses of FILT_LEN-1 samples must never pass.
        seen_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_a = 1'b1;
            tick(3);
            din_a = 1'b0;
            tick(3);
        end
        check("glitch_dout", dout_a, 1'b0);
        check("glitch_pulse", seen_a, 1'b0);
        check("glitch_valid", evt_a.evt_valid, 1'b0);

        // Held din: dout flips on the fourth edge, event one edge later.
        din_a = 1'b1;
        tick(3);
        check("lat_before", dout_a, 1'b0);
        tick(1);
        check("lat_dout", dout_a, 1'b1);
        check("lat_rise", rise_a, 1'b1);
        check("lat_fall", fall_a, 1'b0);
        check("lat_valid_early", evt_a.evt_valid, 1'b0);
        tick(1);
        check("lat_rise_done", rise_a, 1'b0);
        check("ev1_valid", evt_a.evt_valid, 1'b1);
        check("ev1_edge", evt_a.evt_edge, 1'b1);
        check("ev1_count", evt_a.evt_count, 8'd1);
        evt_a.evt_ready = 1'b1;
        tick(1);
        check("ev1_drained", evt_a.evt_valid, 1'b0);
        evt_a.evt_ready = 1'b0;

        // Overflow: rise held, fall dropped; drain, then a new rise reports count 3.
        pulse_reset();
        din_a = 1'b1;
        tick(4);
        check("ovf_rise", rise_a, 1'b1);
        tick(7);
        din_a = 1'b0;
        tick(4);
        check("ovf_fall", fall_a, 1'b1);
        tick(1);
        check("ovf_valid", evt_a.evt_valid, 1'b1);
        check("ovf_held_edge", evt_a.evt_edge, 1'b1);
        check("ovf_held_count", evt_a.evt_count, 8'd1);
        check("ovf_flag", evt_a.evt_ovf, 1'b1);
        evt_a.evt_ready = 1'b1;
        tick(1);
        check("ovf_drained", evt_a.evt_valid, 1'b0);
        evt_a.evt_ready = 1'b0;
        din_a = 1'b1;
        tick(5);
        check("ev3_valid", evt_a.evt_valid, 1'b1);
        check("ev3_count", evt_a.evt_count, 8'd3);
        check("ovf_sticky", evt_a.evt_ovf, 1'b1);

        // Clear, then a new edge arriving while the held one is accepted.
        evt_a.ovf_clr = 1'b1;
        tick(1);
        evt_a.ovf_clr = 1'b0;
        check("clr_ovf", evt_a.evt_ovf, 1'b0);
        din_a = 1'b0;
        tick(4);
        check("swap_fall", fall_a, 1'b1);
        evt_a.evt_ready = 1'b1;
        tick(1);
        evt_a.evt_ready = 1'b0;
        check("swap_valid", evt_a.evt_valid, 1'b1);
        check("swap_edge", evt_a.evt_edge, 1'b0);
        check("swap_count", evt_a.evt_count, 8'd4);
        check("swap_no_ovf", evt_a.evt_ovf, 1'b0);

        // Drop and clear in the same cycle: set wins; clear alone then clears.
        din_a = 1'b1;
        tick(4);
        check("dc_rise", rise_a, 1'b1);
        evt_a.ovf_clr = 1'b1;
        tick(1);
        check("dc_set_wins", evt_a.evt_ovf, 1'b1);
        check("dc_held_count", evt_a.evt_count, 8'd4);
        tick(1);
        check("dc_clr_alone", evt_a.evt_ovf, 1'b0);
        evt_a.ovf_clr = 1'b0;

        // Asynchronous reset in mid-filter with dout=1 and an event held.
        din_a = 1'b0;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", dout_a, 1'b0);
        check("arst_valid", evt_a.evt_valid, 1'b0);
        check("arst_count", evt_a.evt_count, 8'd0);
        check("arst_ovf", evt_a.evt_ovf, 1'b0);
        @(negedge clk_rx);
        rst_n = 1'b1;
        seen_a = 1'b0;
        tick(8);
        check("post_rst_dout", dout_a, 1'b0);
        check("post_rst_pulse", seen_a, 1'b0);
        check("post_rst_valid", evt_a.evt_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sync_evt_filter

// File: doc/sync_evt_filter.md
Name: sync_evt_filter

Overview:
- Stage directly downstream of the sync_ff two-flop synchronizer, in the clk_rx domain.
- Takes the synchronized single-bit level and removes glitches with a stable-count filter.
- Emits the filtered level and one-cycle rise/fall pulses.
- Presents each filtered edge as a timestamped event on a valid/ready handshake, with sticky overflow reporting.

Parameters:
- FILT_LEN, 4, consecutive sampled cycles din must differ from dout before dout flips; legal range 1..255.
- CNT_W, 8, width of the edge counter and of evt_count.
- RST_VAL, 0, reset value of dout.

Ports:
- clk_rx  input  1  receive-domain clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk_rx.
- din  input  1  level from the sync_ff dout, already in the clk_rx domain.
- dout  output  1  filtered level.
- rise_pulse  output  1  one-cycle pulse in the cycle dout goes 0->1.
- fall_pulse  output  1  one-cycle pulse in the cycle dout goes 1->0.
- evt_valid  output  1  an event is held.
- evt_ready  input  1  consumer accepts the held event.
- evt_edge  output  1  1 = rise, 0 = fall; valid while evt_valid=1.
- evt_count  output  CNT_W  edge count including this edge; valid while evt_valid=1.
- evt_ovf  output  1  sticky flag: an event was dropped.
- ovf_clr  input  1  clears evt_ovf.

Behaviour:
- Reset values: dout=RST_VAL; rise_pulse, fall_pulse, evt_valid, evt_edge, evt_ovf = 0; evt_count=0; internal filter counter and edge counter = 0.
- Filter counter:
  - Increments on each edge where din != dout.
  - Clears to 0 on any edge where din == dout.
  - When it would reach FILT_LEN, dout toggles on that edge and the counter clears.
  - Latency: din changes before edge E0 and holds; dout changes at edge E0+FILT_LEN-1.
  - FILT_LEN=1 gives dout = din delayed by one register.
  - A pulse on din of FILT_LEN-1 cycles or fewer never reaches dout.
- Edge pulses:
  - Registered, asserted for exactly one cycle, and coincident with the new dout value.
  - Never both high in the same cycle.
- Edge counter:
  - Increments by 1 on every filtered edge, rise or fall.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Event holding register (one entry) on each filtered edge:
  - If evt_valid=0, or evt_valid=1 with evt_ready=1 in that same cycle: load evt_edge and evt_count (post-increment value); evt_valid=1 next cycle.
  - If evt_valid=1 and evt_ready=0: keep the held event unchanged, drop the new one, set evt_ovf. The edge counter still increments.
- Handshake:
  - Transfer occurs on an edge with evt_valid=1 and evt_ready=1.
  - evt_valid falls next cycle unless a new event loads in the same cycle.
  - evt_edge and evt_count are stable while evt_valid=1 and not accepted.
  - evt_ready while evt_valid=0 is ignored.
- evt_ovf: cleared by ovf_clr=1 on an edge. If a drop and ovf_clr occur in the same cycle, set wins and evt_ovf=1.
- Reset release with din != RST_VAL: the filter runs normally; dout flips after FILT_LEN cycles and produces a pulse and an event. This is intended.
- Reset mid-operation: all state returns to reset values asynchronously; any held event is lost and no pulse is emitted.
- din is assumed already synchronized; this block adds no metastability stages.

Decomposition:
- Package sync_evt_pkg: EDGE_FALL=1'b0, EDGE_RISE=1'b1, FILT_LEN_MAX=255.
- Filter counter width is derived from FILT_LEN with $clog2(FILT_LEN+1).
- One sub-module, sync_glitch_filt (din -> dout, rise_pulse, fall_pulse), reusable on other synchronized inputs.
- The top holds the edge counter, event register and overflow logic.

Test Plan:
- Defaults, reset release with din=0, din raised and held at cycle 10 → dout=1 and rise_pulse=1 at edge 13; event {edge=1, count=1} valid at edge 14; evt_ready=1 clears evt_valid next cycle.
- din high for 3 cycles, then low; repeat 5 times → dout stays 0, no pulses, evt_valid stays 0, edge counter stays 0.
- evt_ready held 0; two filtered edges (rise, then fall 10 cycles later) → evt_valid=1 with {1,1} retained, evt_ovf=1; next accepted event carries count=3 after a further rise.
- Event held, new edge, evt_ready=1 in the same cycle → no overflow; evt_valid stays 1 with the new {edge, count}.
- CNT_W=2, 5 edges each accepted immediately → evt_count sequence 1,2,3,0,1.
- Drop and ovf_clr in the same cycle → evt_ovf=1; ovf_clr alone next cycle → evt_ovf=0. rst_n pulsed low mid-filter (counter=2) → outputs return to reset values at once, no event after release while din=0.
